i2s_adc_to_fix: RTL and testbench



---
 rtl/i2s_adc_to_fix.sv | 175 +++++++++++++++++
 tb/tb_i2s_adc_to_fix.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_to_fix.sv
// I2S ADC capture: deserializes 16-bit L/R words and emits signed fixed-point pairs.
// Optional ROUND_EN: round half up instead of truncating toward -inf.
module i2s_adc_to_fix #(
    parameter int ws = 16,
    parameter int dp = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic                 adclrck,
    input  logic                 adcdat,
    output logic signed [ws-1:0] out_l,
    output logic signed [ws-1:0] out_r,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 frame_err
);

    localparam int SH = 15 - dp;
`ifdef ROUND_EN
    localparam logic [16:0] RND = (17'd1 << SH) >> 1;
`endif

    typedef enum logic [1:0] {SYNC, SHIFT, HOLD} st_t;

    logic                 bclk_s1_q, bclk_s2_q, bclk_prev_q;
    logic                 lrck_s1_q, lrck_s2_q;
    logic                 dat_s1_q, dat_s2_q;
    logic                 lrck_last_q, lrck_last_d;
    logic                 lrck_vld_q, lrck_vld_d;
    st_t                  state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [14:0]          sh_q, sh_d;
    logic [15:0]          left_q, left_d;
    logic                 left_vld_q, left_vld_d;
    logic signed [ws-1:0] out_l_q, out_l_d;
    logic signed [ws-1:0] out_r_q, out_r_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 ferr_q, ferr_d;

    logic        rise, tog, pair;
    logic [15:0] word;

    // 16-bit sample to fixed point, sign-extended/truncated to ws
    function automatic logic signed [ws-1:0] conv(input logic [15:0] s);
        logic signed [16:0] e;
        e = signed'({s[15], s});
`ifdef ROUND_EN
        e = e + RND;
`endif
        e = e >>> SH;
        return ws'(e);
    endfunction

    assign rise = bclk_s2_q & ~bclk_prev_q;
    assign tog  = lrck_vld_q & (lrck_s2_q != lrck_last_q);
    assign word = {sh_q, dat_s2_q};

    // Frame FSM on bclk rising edges plus output handshake
    always_comb begin
        lrck_last_d = lrck_last_q;
        lrck_vld_d  = lrck_vld_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        left_d      = left_q;
        left_vld_d  = left_vld_q;
        ferr_d      = 1'b0;
        pair        = 1'b0;
        if (rise) begin
            lrck_last_d = lrck_s2_q;
            lrck_vld_d  = 1'b1;
            // the edge on which the lrck change is seen is the delay slot
            unique case (state_q)
                SYNC, HOLD: begin
                    if (tog) begin
                        state_d = SHIFT;
                        cnt_d   = 5'd0;
                        if (!lrck_s2_q) left_vld_d = 1'b0;
                    end
                end
                SHIFT: begin
                    if (tog) begin
                        ferr_d     = 1'b1;
                        left_vld_d = 1'b0;
                        cnt_d      = 5'd0;
                    end else begin
                        sh_d  = word[14:0];
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            state_d = HOLD;
                            if (!lrck_last_q) begin
                                left_d     = word;
                                left_vld_d = 1'b1;
                            end else if (left_vld_q) begin
                                pair       = 1'b1;
                                left_vld_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        out_l_d = out_l_q;
        out_r_d = out_r_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (pair) begin
            out_l_d = conv(left_q);
            out_r_d = conv(word);
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (pair && valid_q && !out_ready) ovr_d = 1'b1;
        else if (ovr_clr)                  ovr_d = 1'b0;
    end

    // Synchronizers and state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_s1_q   <= 1'b0;
            bclk_s2_q   <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
            lrck_last_q <= 1'b0;
            lrck_vld_q  <= 1'b0;
            state_q     <= SYNC;
            cnt_q       <= 5'd0;
            sh_q        <= '0;
            left_q      <= '0;
            left_vld_q  <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            bclk_s1_q   <= bclk;
            bclk_s2_q   <= bclk_s1_q;
            bclk_prev_q <= bclk_s2_q;
            lrck_s1_q   <= adclrck;
            lrck_s2_q   <= lrck_s1_q;
            dat_s1_q    <= adcdat;
            dat_s2_q    <= dat_s1_q;
            lrck_last_q <= lrck_last_d;
            lrck_vld_q  <= lrck_vld_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            left_q      <= left_d;
            left_vld_q  <= left_vld_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_adc_to_fix.sv
// Directed bench for i2s_adc_to_fix: I2S frames at bclk = clk/16, 32 slots per half.
// Expected values are hand-computed for ws=16, dp=8.
module tb_i2s_adc_to_fix;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               bclk = 1'b0;
    logic               adclrck = 1'b1;
    logic               adcdat = 1'b0;
    logic signed [15:0] out_l, out_r;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               overrun;
    logic               ovr_clr = 1'b0;
    logic               frame_err;

    int n_chk = 0;
    int n_fail = 0;
    int n_vcyc = 0;
    int n_acc = 0;
    int n_ferr = 0;
    int acc_l = 0;
    int acc_r = 0;
    int p0, v0, f0;

    i2s_adc_to_fix #(.ws(16), .dp(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .adclrck   (adclrck),
        .adcdat    (adcdat),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // observe outputs away from the active edge
    always @(negedge clk) begin
        if (out_valid) n_vcyc++;
        if (frame_err) n_ferr++;
        if (out_valid && out_ready) begin
            n_acc++;
            acc_l = int'(out_l);
            acc_r = int'(out_r);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic slot(input logic lr, input logic d, input bit pulse);
        bclk    = 1'b0;
        adclrck = lr;
        adcdat  = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        if (pulse) begin
            // rise is seen two clk later; ready is high on the edge that loads the pair
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            check("same_cyc_valid", int'(out_valid), 1);
            check("same_cyc_l", int'(out_l), 4);
            check("same_cyc_ovr", int'(overrun), 0);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic half(input logic lr, input logic [15:0] w,
                        input int nslot, input bit pulse);
        for (int i = 0; i < nslot; i++) begin
            logic b;
            b = 1'b0;
            if (i >= 1 && i <= 16) b = w[16-i];
            slot(lr, b, pulse && (i == 16));
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         input bit pulse);
        half(1'b0, l, 32, 1'b0);
        half(1'b1, r, 32, pulse);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_l", int'(out_l), 0);
        check("rst_r", int'(out_r), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_ferr", int'(frame_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // first pair is lost while locking onto lrck
        p0 = n_acc; v0 = n_vcyc; f0 = n_ferr;
        repeat (3) frame(16'h4000, 16'hC000, 1'b0);
        check("basic_pairs", n_acc - p0, 2);
        check("basic_vcyc", n_vcyc - v0, 2);
        check("basic_l", acc_l, 128);
        check("basic_r", acc_r, -128);
        check("basic_ferr", n_ferr - f0, 0);

        frame(16'h7FFF, 16'h8000, 1'b0);
`ifdef ROUND_EN
        check("max_l", acc_l, 256);
`else
        check("max_l", acc_l, 255);
`endif
        check("min_r", acc_r, -256);
        frame(16'h0040, 16'hFFC0, 1'b0);
`ifdef ROUND_EN
        check("small_l", acc_l, 1);
        check("small_r", acc_r, 0);
`else
        check("small_l", acc_l, 0);
        check("small_r", acc_r, -1);
`endif

        // overrun with consumer stalled
        out_ready = 1'b0;
        frame(16'h0080, 16'h0000, 1'b0);
        check("stall_valid", int'(out_valid), 1);
        check("stall_l", int'(out_l), 1);
        check("stall_ovr", int'(overrun), 0);
        frame(16'h0100, 16'h0000, 1'b0);
        check("ovr_set", int'(overrun), 1);
        check("ovr_l", int'(out_l), 2);
        check("ovr_valid", int'(out_valid), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);
        check("ovr_clr_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("drain_valid", int'(out_valid), 0);
        check("drain_l", acc_l, 2);

        // short left word: 10 bits then lrck toggles
        p0 = n_acc; f0 = n_ferr;
        half(1'b0, 16'hAAAA, 11, 1'b0);
        half(1'b1, 16'h1111, 32, 1'b0);
        check("short_ferr", n_ferr - f0, 1);
        check("short_pairs", n_acc - p0, 0);
        frame(16'h0080, 16'h0000, 1'b0);
        check("after_short_pairs", n_acc - p0, 1);
        check("after_short_l", acc_l, 1);
        check("after_short_r", acc_r, 0);

        // reset in the middle of a right word
        half(1'b0, 16'h1234, 32, 1'b0);
        for (int i = 0; i < 8; i++) slot(1'b1, 1'b1, 1'b0);
        bclk = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_l", int'(out_l), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_l", int'(out_l), 0);
        check("post_rst_r", int'(out_r), 0);
        p0 = n_acc;
        repeat (2) frame(16'hFF80, 16'h0000, 1'b0);
        check("rst_resume_pairs", n_acc - p0, 1);
        check("rst_resume_l", acc_l, -1);
        check("rst_resume_r", acc_r, 0);

        // accept and new pair on the same clk
        out_ready = 1'b0;
        frame(16'h0100, 16'h0000, 1'b0);
        check("pre_same_valid", int'(out_valid), 1);
        check("pre_same_l", int'(out_l), 2);
        frame(16'h0200, 16'h0000, 1'b1);
        check("post_same_ovr", int'(overrun), 0);
        check("post_same_l", int'(out_l), 4);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("final_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
